up_down_counter16_core: RTL

Synthesisable 16-bit up/down counter with synchronous load. It is the counter that the team's up/down counter property checker binds to and observes. On top of the bare counter it adds terminal-count detection, a registered wrap pulse and sticky overflow/underflow flags, so the surrounding logic can chain or interrupt on boundary crossings.

---
 rtl/up_down_counter_pkg.sv | 16 +
 rtl/up_down_counter16_core_event_flags.sv | 50 +++++
 rtl/up_down_counter16_core.sv | 66 ++++++
 3 files changed

// File: rtl/up_down_counter_pkg.sv
// Shared types and constants for the 16-bit up/down counter slice.
package up_down_counter_pkg;

  localparam int unsigned CNT_WIDTH = 16;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;
  localparam cnt_t CNT_MIN = '0;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/up_down_counter16_core_event_flags.sv
// Wrap pulse and sticky overflow/underflow flags for the up/down counter.
// COUNTER_SAT_EN: saturating build suppresses the wrap pulse; flags still set.
module counter_event_flags
  import up_down_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic wrap_cond_i,
  input  dir_e dir_i,
  input  logic clr_flags_i,
  output logic wrap_o,
  output logic ovf_o,
  output logic unf_o
);

  logic wrap_q, wrap_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // A new crossing overrides a same-edge clear, so set is ORed in after the clear.
  always_comb begin
    wrap_d = 1'b0;
    ovf_d  = ovf_q & ~clr_flags_i;
    unf_d  = unf_q & ~clr_flags_i;
`ifdef COUNTER_SAT_EN
    wrap_d = 1'b0;
`else
    wrap_d = wrap_cond_i;
`endif
    if (wrap_cond_i && dir_i == DIR_UP)   ovf_d = 1'b1;
    if (wrap_cond_i && dir_i == DIR_DOWN) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign wrap_o = wrap_q;
  assign ovf_o  = ovf_q;
  assign unf_o  = unf_q;

endmodule

// File: rtl/up_down_counter16_core.sv
// 16-bit up/down counter with active-low synchronous load and terminal count.
// COUNTER_SAT_EN: saturate at the boundaries instead of wrapping.
module up_down_counter16_core
  import up_down_counter_pkg::*;
#(
  parameter int unsigned       WIDTH   = 16,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_enb,
  input  logic             updn_cnt,
  input  logic             ld_cnt,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             wrap,
  output logic             ovf_flag,
  output logic             unf_flag
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] data_q, data_d;
  dir_e             dir;
  logic             at_bound;

  always_comb begin
    dir      = dir_e'(updn_cnt);
    at_bound = (dir == DIR_UP) ? (data_q == '1) : (data_q == '0);
    tc       = count_enb & ld_cnt & at_bound;
  end

  always_comb begin
    data_d = data_q;
    if (!ld_cnt) begin
      data_d = data_in;
    end else if (count_enb) begin
`ifdef COUNTER_SAT_EN
      if (!at_bound) data_d = (dir == DIR_UP) ? data_q + ONE : data_q - ONE;
`else
      data_d = (dir == DIR_UP) ? data_q + ONE : data_q - ONE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= RST_VAL;
    else     data_q <= data_d;
  end

  assign data_out = data_q;

  counter_event_flags u_flags (
    .clk         (clk),
    .rst         (rst),
    .wrap_cond_i (tc),
    .dir_i       (dir),
    .clr_flags_i (clr_flags),
    .wrap_o      (wrap),
    .ovf_o       (ovf_flag),
    .unf_o       (unf_flag)
  );

endmodule
